// File: rtl/x_dcr_pkg.sv
// Shared types and helpers for the DCR register-bank slave.
package x_dcr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } dcr_state_e;

    localparam int DCR_MAX_WAIT = 15;
    localparam int DCR_MAX_REGS = 64;

    // Register index width; a single-register window still carries one index bit.
    function automatic int dcr_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/x_dcr_addr_decode.sv
// Window decode: flags addresses inside [BASE_ADDR, BASE_ADDR+NUM_REGS) and yields the slot index.
module x_dcr_addr_decode
    import x_dcr_pkg::*;
#(
    parameter int                    ABUS_WIDTH = 10,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ABUS_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic [0:ABUS_WIDTH-1]              i_abus,
    output logic                               o_hit,
    output logic [dcr_idx_w(NUM_REGS)-1:0]     o_idx
);

    localparam int IDX_W = dcr_idx_w(NUM_REGS);
    // Widened so BASE_ADDR+NUM_REGS cannot wrap at the top of the address space.
    localparam int EXT_W = ABUS_WIDTH + 8;

    logic [EXT_W-1:0] w_addr;
    logic [EXT_W-1:0] w_base;
    logic [EXT_W-1:0] w_off;

    assign w_addr = EXT_W'(i_abus);
    assign w_base = EXT_W'(BASE_ADDR);
    assign w_off  = w_addr - w_base;
    assign o_hit  = (w_addr >= w_base) && (w_off < EXT_W'(NUM_REGS));
    assign o_idx  = IDX_W'(w_off);

endmodule

// File: rtl/x_dcr_regbank.sv
// Parametrised DCR daisy-chain slave: register window with wait states, RO status slots and pass-through.
module x_dcr_regbank
    import x_dcr_pkg::*;
#(
    parameter int                    ABUS_WIDTH  = 10,
    parameter int                    DBUS_WIDTH  = 32,
    parameter int                    NUM_REGS    = 4,
    parameter logic [ABUS_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DBUS_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [0:ABUS_WIDTH-1]          DCRABUS,
    input  logic                           DCRREAD,
    input  logic                           DCRWRITE,
    input  logic [0:DBUS_WIDTH-1]          DCRDBUSIN,
    output logic [0:DBUS_WIDTH-1]          DCRDBUSOUT,
    output logic                           DCRACK,
    input  logic [NUM_REGS*DBUS_WIDTH-1:0] REGIN,
    output logic [NUM_REGS*DBUS_WIDTH-1:0] REGOUT,
    output logic [NUM_REGS-1:0]            REGWR,
    output logic                           PROTERR
);

    localparam int         IDX_W   = dcr_idx_w(NUM_REGS);
    localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    if (WAIT_STATES < 0 || WAIT_STATES > DCR_MAX_WAIT) begin : g_bad_ws
        $error("x_dcr_regbank: WAIT_STATES out of range");
    end
    if (NUM_REGS < 1 || NUM_REGS > DCR_MAX_REGS) begin : g_bad_nr
        $error("x_dcr_regbank: NUM_REGS out of range");
    end

    dcr_state_e            r_state;
    logic [3:0]            r_wcnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_is_wr;
    logic                  r_ack;
    logic                  r_armed;
    logic                  r_proterr;
    logic [NUM_REGS-1:0]   r_regwr;
    logic [DBUS_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DBUS_WIDTH-1:0] r_rdata;

    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_req;
    logic                  w_single;
    logic                  w_start;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_cidx;
    logic                  w_cwr;

    x_dcr_addr_decode #(
        .ABUS_WIDTH (ABUS_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .i_abus (DCRABUS),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_req    = DCRREAD | DCRWRITE;
    assign w_single = DCRREAD ^ DCRWRITE;
    // r_armed blocks a request that is still high from the previous transfer.
    assign w_start  = (r_state == ST_IDLE) && w_hit && w_single && r_armed;
    assign w_commit = (w_start && (WAIT_STATES == 0)) ||
                      ((r_state == ST_WAIT) && w_req && (r_wcnt == 4'd0));
    assign w_cidx   = (r_state == ST_IDLE) ? w_idx : r_idx;
    assign w_cwr    = (r_state == ST_IDLE) ? DCRWRITE : r_is_wr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= 4'd0;
            r_idx     <= '0;
            r_is_wr   <= 1'b0;
            r_ack     <= 1'b0;
            r_armed   <= 1'b1;
            r_proterr <= 1'b0;
        end else begin
            if (w_hit && DCRREAD && DCRWRITE) r_proterr <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (!w_req) r_armed <= 1'b1;
                    if (w_start) begin
                        r_idx   <= w_idx;
                        r_is_wr <= DCRWRITE;
                        r_wcnt  <= WS_INIT;
                        if (WAIT_STATES == 0) begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_armed <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (r_wcnt == 4'd0) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_armed <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
            r_rdata <= '0;
            r_regwr <= '0;
        end else begin
            r_regwr <= '0;
            if (w_commit) begin
                if (w_cwr) begin
                    // Writes to RO slots are acknowledged but silently dropped.
                    if (!RO_MASK[w_cidx]) begin
                        r_regs[w_cidx]  <= DCRDBUSIN;
                        r_regwr[w_cidx] <= 1'b1;
                    end
                end else begin
                    r_rdata <= RO_MASK[w_cidx] ? REGIN[w_cidx*DBUS_WIDTH +: DBUS_WIDTH]
                                               : r_regs[w_cidx];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regout
        assign REGOUT[g*DBUS_WIDTH +: DBUS_WIDTH] = RO_MASK[g] ? '0 : r_regs[g];
    end

    assign DCRDBUSOUT = (r_ack && !r_is_wr) ? r_rdata : DCRDBUSIN;
    assign DCRACK     = r_ack;
    assign REGWR      = r_regwr;
    assign PROTERR    = r_proterr;

endmodule

// File: tb/tb_x_dcr_regbank.sv
// Scoreboard bench: two slaves (no wait states with RO slot 0, and three wait states) on one address bus.
module tb_x_dcr_regbank;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   abus;
    logic [31:0]  dbin;
    logic [127:0] regin;
    logic         rd0, wr0, rd1, wr1;
    logic [31:0]  dbout0, dbout1;
    logic         ack0, ack1;
    logic [127:0] regout0, regout1;
    logic [3:0]   regwr0, regwr1;
    logic         perr0, perr1;

    localparam logic [31:0] RV0 = 32'h0000_1234;
    localparam logic [3:0]  RO0 = 4'b0001;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl [2][4];

    always #5 clk = ~clk;

    x_dcr_regbank #(
        .ABUS_WIDTH(10), .DBUS_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(10'h080),
        .WAIT_STATES(0), .RO_MASK(RO0), .RESET_VAL(RV0)
    ) u_dut0 (
        .CLK(clk), .RST(rst), .DCRABUS(abus), .DCRREAD(rd0), .DCRWRITE(wr0),
        .DCRDBUSIN(dbin), .DCRDBUSOUT(dbout0), .DCRACK(ack0), .REGIN(regin),
        .REGOUT(regout0), .REGWR(regwr0), .PROTERR(perr0)
    );

    x_dcr_regbank #(
        .ABUS_WIDTH(10), .DBUS_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(10'h080),
        .WAIT_STATES(3), .RO_MASK(4'b0000), .RESET_VAL(32'h0)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .DCRABUS(abus), .DCRREAD(rd1), .DCRWRITE(wr1),
        .DCRDBUSIN(dbin), .DCRDBUSOUT(dbout1), .DCRACK(ack1), .REGIN(regin),
        .REGOUT(regout1), .REGWR(regwr1), .PROTERR(perr1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_ack(input int sel);
        return (sel == 0) ? 32'(ack0) : 32'(ack1);
    endfunction
    function automatic logic [31:0] f_wr(input int sel);
        return (sel == 0) ? 32'(regwr0) : 32'(regwr1);
    endfunction
    function automatic logic [31:0] f_out(input int sel);
        return (sel == 0) ? dbout0 : dbout1;
    endfunction
    function automatic logic [31:0] f_perr(input int sel);
        return (sel == 0) ? 32'(perr0) : 32'(perr1);
    endfunction
    function automatic logic [31:0] f_slot(input int sel, input int i);
        logic [127:0] t;
        t = (sel == 0) ? regout0 : regout1;
        return t[i*32 +: 32];
    endfunction

    task automatic set_req(input int sel, input logic r, input logic w);
        if (sel == 0) begin rd0 = r; wr0 = w; end
        else          begin rd1 = r; wr1 = w; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mdl[0][i] = RV0;
            mdl[1][i] = 32'h0;
        end
    endtask

    task automatic chk_regs(input int sel);
        for (int i = 0; i < 4; i++)
            chk($sformatf("regout%0d_slot%0d", sel, i), f_slot(sel, i),
                (sel == 0 && RO0[i]) ? 32'h0 : mdl[sel][i]);
    endtask

    // One complete transfer on a hit address; expectations come from the model.
    task automatic xfer(input int sel, input logic [9:0] addr, input bit is_wr, input logic [31:0] data);
        int          idx, ws, n;
        bit          ro, got;
        logic [3:0]  exp_wr;
        logic [31:0] exp_rd;
        idx    = int'(addr) - 'h80;
        ws     = (sel == 0) ? 0 : 3;
        ro     = (sel == 0) && RO0[idx];
        exp_wr = (is_wr && !ro) ? (4'b0001 << idx) : 4'b0000;
        exp_rd = 32'h0;
        abus   = addr;
        dbin   = data;
        if (!is_wr) exp_q.push_back(ro ? regin[idx*32 +: 32] : mdl[sel][idx]);
        set_req(sel, !is_wr, is_wr);
        n   = 0;
        got = 0;
        while (!got && n < ws + 6) begin
            tick();
            n++;
            if (f_ack(sel) == 32'd1) got = 1;
        end
        chk("ack_latency", 32'(n), 32'(ws + 1));
        if (got) begin
            if (is_wr && !ro) mdl[sel][idx] = data;
            chk("regwr_strobe", f_wr(sel), 32'(exp_wr));
            if (is_wr) begin
                chk_regs(sel);
            end else if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_rd = exp_q.pop_front();
                chk("read_data", f_out(sel), exp_rd);
            end
            tick();
            chk("ack_hold", f_ack(sel), 32'd1);
            chk("regwr_one_cycle", f_wr(sel), 32'd0);
            if (!is_wr) chk("read_data_hold", f_out(sel), exp_rd);
        end
        set_req(sel, 1'b0, 1'b0);
        tick();
        chk("ack_drop", f_ack(sel), 32'd0);
        tick();
    endtask

    task automatic miss(input logic [9:0] addr);
        abus = addr;
        dbin = 32'h1234_5678;
        wr0  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("miss_ack", f_ack(0), 32'd0);
            chk("miss_passthru", f_out(0), 32'h1234_5678);
            chk("miss_regwr", f_wr(0), 32'd0);
        end
        wr0 = 1'b0;
        tick();
        chk_regs(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        abus  = 10'h0;
        dbin  = 32'hCAFE_D00D;
        regin = {32'h4444_4444, 32'h3333_3333, 32'h1111_1111, 32'hA5A5_A5A5};
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        chk("rst_ack0", f_ack(0), 32'd0);
        chk("rst_ack1", f_ack(1), 32'd0);
        chk("rst_regwr0", f_wr(0), 32'd0);
        chk("rst_perr0", f_perr(0), 32'd0);
        chk("rst_passthru", f_out(0), 32'hCAFE_D00D);
        chk_regs(0);
        chk_regs(1);

        xfer(0, 10'h082, 1'b1, 32'hDEAD_BEEF);
        xfer(0, 10'h082, 1'b0, 32'h0);
        xfer(0, 10'h081, 1'b1, 32'h0BAD_F00D);
        xfer(0, 10'h083, 1'b0, 32'h0);
        xfer(0, 10'h083, 1'b1, 32'h7777_0003);
        xfer(0, 10'h081, 1'b0, 32'h0);

        xfer(1, 10'h081, 1'b1, 32'hCAFE_0001);
        xfer(1, 10'h081, 1'b0, 32'h0);

        // Request dropped during the wait phase: nothing may complete.
        abus = 10'h081;
        rd1  = 1'b1;
        tick();
        chk("abort_ack_e1", f_ack(1), 32'd0);
        tick();
        rd1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_ack", f_ack(1), 32'd0);
        end
        chk_regs(1);
        xfer(1, 10'h080, 1'b0, 32'h0);

        miss(10'h084);
        miss(10'h07F);

        xfer(0, 10'h080, 1'b1, 32'hFFFF_FFFF);
        xfer(0, 10'h080, 1'b0, 32'h0);

        abus = 10'h080;
        rd0  = 1'b1;
        wr0  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("both_ack", f_ack(0), 32'd0);
            chk("both_perr", f_perr(0), 32'd1);
        end
        rd0 = 1'b0;
        wr0 = 1'b0;
        repeat (2) tick();
        chk("perr_sticky", f_perr(0), 32'd1);
        chk("perr_other", f_perr(1), 32'd0);
        chk_regs(0);

        // Asynchronous reset while a write is being acknowledged.
        abus = 10'h081;
        dbin = 32'h55AA_55AA;
        wr0  = 1'b1;
        tick();
        chk("pre_rst_ack", f_ack(0), 32'd1);
        chk("pre_rst_regwr", f_wr(0), 32'd2);
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", f_ack(0), 32'd0);
        chk("rst_mid_regwr", f_wr(0), 32'd0);
        chk("rst_mid_perr", f_perr(0), 32'd0);
        model_reset();
        chk_regs(0);
        wr0 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_regs(1);
        xfer(0, 10'h081, 1'b0, 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
